systolic_array_nxn: RTL and testbench
=====================================

# systolic_array_nxn

Parametrised output-stationary systolic matrix-multiply engine, the generalised successor of the fixed 8x8 array. Computes C = A·B (or C += A·B) for an N×N output tile with a runtime reduction length up to KMAX. Adds a start/busy/done handshake, accumulate mode for K-tiling, and optional saturating accumulation. It sits between the tile loader, which presents the A/B operand tiles, and the result writeback, which reads C on done.

## Interface
- DATA_WIDTH, 16: signed operand width.
- ACC_WIDTH, 32: signed accumulator width. Must be ≥ 2·DATA_WIDTH; elaboration fails otherwise.
- N, 8: array rows and columns, range 2..16.
- KMAX, 8: maximum reduction length, ≥ 1.
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: request a computation. Sampled only in IDLE.
- acc_mode  in  1: sampled with start. 0 = clear accumulators first; 1 = add onto the existing C.
- k_len  in  $clog2(KMAX+1): reduction length, sampled with start.
- a_matrix  in  [0:N-1][0:KMAX-1]×DATA_WIDTH: operand A. Must be held stable while busy.
- b_matrix  in  [0:KMAX-1][0:N-1]×DATA_WIDTH: operand B. Must be held stable while busy.
- c_out  out  [0:N-1][0:N-1]×ACC_WIDTH: accumulator array, driven directly from PE registers.
- busy  out  1: high in COMPUTE.
- done  out  1: one-cycle registered pulse when C is final.
- ovf  out  1: sticky saturation flag (see Configuration).

## Operation
- States:
  - IDLE: start=1 moves to COMPUTE, or to DONE if the effective k_len is 0.
  - COMPUTE: runs L = k_len_eff + 2N − 2 cycles, counter t = 0..L−1, then moves to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- k_len_eff = min(k_len, KMAX). k_len and acc_mode are latched at start acceptance.
- On start acceptance:
  - All operand pipeline registers are cleared.
  - If acc_mode=0, all accumulators and ovf are cleared.
  - If acc_mode=1, accumulators and ovf are retained.
- Feed in COMPUTE:
  - Row input i carries a_matrix[i][k] when t == i+k and k < k_len_eff, otherwise 0.
  - Column input j carries b_matrix[k][j] when t == j+k and k < k_len_eff, otherwise 0.
- Each PE(i,j) performs one update per COMPUTE edge:
  - a → right, b → down (registered forwarding).
  - acc += sext(a·b).
  - The product is a full 2·DATA_WIDTH signed value, sign-extended to ACC_WIDTH.
  - Zero operands contribute nothing.
- PEs are frozen (no forwarding, no accumulation) outside COMPUTE.
- start is ignored while in COMPUTE or DONE. No queuing.
- c_out holds stable from done until the next accepted start (acc_mode=0), or until the first MAC of the next run (acc_mode=1).
- rst asserted at any time, including mid-COMPUTE:
  - State goes to IDLE.
  - t, accumulators, pipeline registers, busy, done and ovf all go to 0.

## Timing
- Reset values: c_out all 0, busy 0, done 0, ovf 0.
- Start sampled at edge E0:
  - busy is high from after E0 to after edge E0+L.
  - done is high for exactly one cycle, after edge E0+L.
- Default N=8, k_len=8: L = 22. done appears after the 22nd edge following E0.
- k_len_eff=0: DONE is entered at E0. done is high the cycle after E0, and busy never rises.
- PE(i,j) accumulates term k at the edge ending COMPUTE cycle t = i+j+k. The final MAC is at PE(N−1,N−1) on edge E0+L, the same edge that asserts done.
- back-to-back: start held high through DONE is accepted on the IDLE cycle that follows, i.e. 2 cycles after done rises.

## Configuration
- SYSTOLIC_SAT_EN defined:
  - Each accumulation saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - ovf is set on any clamp and stays set until reset or the next acc_mode=0 start.
- SYSTOLIC_SAT_EN undefined:
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - ovf is tied to 0.

## Test plan
- Identity: A = I₈, b_matrix[k][j] = 8k+j, k_len=8, acc_mode=0 → c_out[i][j] = 8i+j. done pulses once, exactly 22 edges after the start edge; busy is high for those 22 cycles.
- Partial K: A = all 1, B = all 3, k_len=3 → every c_out = 9. done after 17 edges. The KMAX>k_len columns of the inputs are ignored.
- Accumulate: A = all 1, B = all 2, k_len=8, acc_mode=0 → all C = 16. A second run with acc_mode=1 → all C = 32. A third run with acc_mode=0 → all C = 16.
- Protocol: pulse start again mid-COMPUTE → ignored, with no change to latency or results. Assert rst at t=10 → c_out all 0, busy=0, done=0, state IDLE. k_len=0 with acc_mode=0 → done one cycle later, C all 0.
- Overflow: A = all 32767, B = all 32767, k_len=8 → with SYSTOLIC_SAT_EN, all C = 2147483647 and ovf=1. Without it, all C = −524280 and ovf=0.
- Clamp: k_len=15 with KMAX=8 behaves identically to k_len=8, including the 22-edge latency.

Source files
------------

// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic matrix-multiply engine: C = A*B or C += A*B.
// Optional saturating accumulation and sticky ovf flag: define SYSTOLIC_SAT_EN.

module systolic_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear_pipe,
    input  logic                  clear_acc,
    input  logic [DATA_WIDTH-1:0] a_west,
    input  logic [DATA_WIDTH-1:0] b_north,
    output logic [DATA_WIDTH-1:0] a_east,
    output logic [DATA_WIDTH-1:0] b_south,
    output logic [ACC_WIDTH-1:0]  acc
`ifdef SYSTOLIC_SAT_EN
    ,
    output logic                  clamp
`endif
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]             sum;
    logic [ACC_WIDTH-1:0]           acc_next;

    assign prod = $signed(a_west) * $signed(b_north);
    // One guard bit above the accumulator exposes signed overflow of the add.
    assign sum  = {acc[ACC_WIDTH-1], acc}
                + {{(ACC_WIDTH+1-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

`ifdef SYSTOLIC_SAT_EN
    logic over;
    assign over  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign clamp = en & over;
    always_comb begin
        acc_next = sum[ACC_WIDTH-1:0];
        if (over)
            acc_next = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
    assign acc_next = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_east  <= '0;
            b_south <= '0;
            acc     <= '0;
        end else if (clear_pipe) begin
            a_east  <= '0;
            b_south <= '0;
            if (clear_acc) acc <= '0;
        end else if (en) begin
            a_east  <= a_west;
            b_south <= b_north;
            acc     <= acc_next;
        end
    end
endmodule

module systolic_array_nxn #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int N          = 8,
    parameter int KMAX       = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     acc_mode,
    input  logic [$clog2(KMAX+1)-1:0]                k_len,
    input  logic [0:N-1][0:KMAX-1][DATA_WIDTH-1:0]   a_matrix,
    input  logic [0:KMAX-1][0:N-1][DATA_WIDTH-1:0]   b_matrix,
    output logic [0:N-1][0:N-1][ACC_WIDTH-1:0]       c_out,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     ovf
);
    localparam int KW = $clog2(KMAX+1);
    localparam int TW = $clog2(KMAX+2*N);

    if (ACC_WIDTH < 2*DATA_WIDTH) begin : g_bad_acc
        $error("systolic_array_nxn: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end
    if (N < 2 || N > 16 || KMAX < 1) begin : g_bad_dim
        $error("systolic_array_nxn: N must be 2..16 and KMAX >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FIN} state_t;
    state_t state, state_n;

    logic [KW-1:0] k_eff_in, k_eff_q;
    logic [TW-1:0] t, last_t;
    logic          accept;

    assign k_eff_in = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
    assign accept   = (state == S_IDLE) && start;
    assign last_t   = TW'(k_eff_q) + TW'(2*N-3);
    assign busy     = (state == S_COMPUTE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start) state_n = (k_eff_in == '0) ? S_FIN : S_COMPUTE;
            S_COMPUTE: if (t == last_t) state_n = S_FIN;
            S_FIN:     state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            t       <= '0;
            done    <= 1'b0;
            k_eff_q <= '0;
        end else begin
            state <= state_n;
            done  <= (state_n == S_FIN);
            t     <= (state == S_COMPUTE) ? t + 1'b1 : '0;
            if (accept) k_eff_q <= k_eff_in;
        end
    end

    // Skewed edge feed: term k enters row i at t=i+k and column j at t=j+k.
    logic [N-1:0][DATA_WIDTH-1:0] row_feed, col_feed;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_feed[i] = '0;
            col_feed[i] = '0;
            for (int k = 0; k < KMAX; k++) begin
                if (KW'(k) < k_eff_q && t == TW'(i+k)) begin
                    row_feed[i] = a_matrix[i][k];
                    col_feed[i] = b_matrix[k][i];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] a_bus [N][N+1];
    logic [DATA_WIDTH-1:0] b_bus [N+1][N];
    logic [N*N-1:0]        clamp;

    for (genvar i = 0; i < N; i++) begin : g_row
        assign a_bus[i][0] = row_feed[i];
        assign b_bus[0][i] = col_feed[i];
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
                .clk        (clk),
                .rst        (rst),
                .en         (busy),
                .clear_pipe (accept),
                .clear_acc  (~acc_mode),
                .a_west     (a_bus[i][j]),
                .b_north    (b_bus[i][j]),
                .a_east     (a_bus[i][j+1]),
                .b_south    (b_bus[i+1][j]),
                .acc        (c_out[i][j])
`ifdef SYSTOLIC_SAT_EN
                ,
                .clamp      (clamp[i*N+j])
`endif
            );
        end
    end

    // Operands leaving the far edge of the array have no consumer.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < N; i++)
            unused_edge = unused_edge ^ (^a_bus[i][N]) ^ (^b_bus[N][i]);
    end

`ifdef SYSTOLIC_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    ovf <= 1'b0;
        else if (accept && !acc_mode) ovf <= 1'b0;
        else if (busy && |clamp)    ovf <= 1'b1;
    end
`else
    assign clamp = '0;
    assign ovf   = 1'b0;
    logic unused_clamp;
    assign unused_clamp = ^clamp;
`endif
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Self-checking bench for systolic_array_nxn: directed and random runs vs a plain matrix-multiply model.
module tb_systolic_array_nxn;
    localparam int DW = 16, AW = 32, N = 8, KMAX = 8;

    logic clk = 1'b0;
    logic rst, start, acc_mode;
    logic [3:0] k_len;
    logic [0:N-1][0:KMAX-1][DW-1:0] a_matrix;
    logic [0:KMAX-1][0:N-1][DW-1:0] b_matrix;
    logic [0:N-1][0:N-1][AW-1:0]    c_out;
    logic busy, done, ovf;

    systolic_array_nxn #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .N(N), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .k_len(k_len),
        .a_matrix(a_matrix), .b_matrix(b_matrix), .c_out(c_out),
        .busy(busy), .done(done), .ovf(ovf));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic signed [DW-1:0] A [N][KMAX];
    logic signed [DW-1:0] B [KMAX][N];
    logic signed [AW-1:0] C [N][N];
    logic m_ovf;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic mode, input int klen);
        int keff;
        longint s;
        keff = (klen > KMAX) ? KMAX : klen;
        if (!mode) begin
            m_ovf = 1'b0;
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) C[i][j] = '0;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < keff; k++) begin
                    s = longint'(C[i][j]) + longint'(A[i][k]) * longint'(B[k][j]);
`ifdef SYSTOLIC_SAT_EN
                    if (s > 64'sd2147483647)       begin s = 64'sd2147483647;  m_ovf = 1'b1; end
                    else if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_ovf = 1'b1; end
`endif
                    C[i][j] = s[AW-1:0];
                end
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_c[%0d][%0d]", tag, i, j), 64'($signed(c_out[i][j])), 64'(C[i][j]));
        chk({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
    endtask

    task automatic run(input string tag, input logic mode, input int klen, input int pulse_at);
        int keff, lat, edges, bcnt;
        for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) a_matrix[i][k] = A[i][k];
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) b_matrix[k][j] = B[k][j];
        model(mode, klen);
        keff = (klen > KMAX) ? KMAX : klen;
        lat  = (keff == 0) ? 0 : keff + 2*N - 2;
        @(negedge clk);
        start = 1'b1; acc_mode = mode; k_len = 4'(klen);
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; bcnt = 0;
        while (!done && edges < 200) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            edges++;
            start = (edges == pulse_at);
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(edges), 64'(lat));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(lat));
        check_c(tag);
        @(posedge clk); #1;
        chk({tag, "_done_width"}, 64'(done), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_c({tag, "_hold"});
    endtask

    task automatic fill(input int a_kind, input int b_kind);
        for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++)
            A[i][k] = (a_kind < 0) ? 16'($urandom) : DW'(a_kind);
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++)
            B[k][j] = (b_kind < 0) ? 16'($urandom) : DW'(b_kind);
    endtask

    initial begin
        int nz;
        rst = 1'b1; start = 1'b0; acc_mode = 1'b0; k_len = '0;
        a_matrix = '0; b_matrix = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) C[i][j] = '0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_c("reset");
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Identity A, B[k][j] = 8k+j
        for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) A[i][k] = (i == k) ? 16'sd1 : 16'sd0;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) B[k][j] = DW'(8*k + j);
        run("identity", 1'b0, 8, -1);

        // Partial K: columns beyond k_len hold garbage that must be ignored
        fill(1, 3);
        for (int i = 0; i < N; i++) for (int k = 3; k < KMAX; k++) A[i][k] = 16'($urandom);
        run("partial", 1'b0, 3, -1);

        fill(1, 2);
        run("acc0", 1'b0, 8, -1);
        run("acc1_pulse", 1'b1, 8, 5);
        run("acc0_again", 1'b0, 8, -1);

        // Reset in COMPUTE cycle t=10
        fill(-1, -1);
        @(negedge clk); start = 1'b1; acc_mode = 1'b0; k_len = 4'd8;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1; #1;
        nz = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) if (c_out[i][j] !== '0) nz++;
        chk("midrst_c_nonzero", 64'(nz), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) C[i][j] = '0;
        m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("midrst_idle_busy", 64'(busy), 64'd0);
        run("post_rst_acc1", 1'b1, 5, -1);

        fill(-1, -1);
        run("pre_k0", 1'b0, 8, -1);
        run("k0_clear", 1'b0, 0, -1);

        fill(32767, 32767);
        run("overflow", 1'b0, 8, -1);
        run("overflow_acc", 1'b1, 8, -1);

        fill(-1, -1);
        run("clamp_k15", 1'b0, 15, -1);

        for (int r = 0; r < 6; r++) begin
            fill(-1, -1);
            run($sformatf("rand%0d", r), 1'($urandom_range(1)), int'($urandom_range(15)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
